// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BITS,
        STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 20_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);

    logic          rx_meta_q, rx_sync_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

    // Synchronizer and receiver state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Bit timing: recheck start at half a bit, then sample every full bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? IDLE : BITS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BITS: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: parses a framed program image from UART and writes it into imem, gating core reset.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 20_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic                          imem_we,
    output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
    output logic [31:0]                   imem_data,
    output logic                          core_reset,
    output logic                          done,
    output logic                          error
);

    localparam int unsigned AW    = $clog2(IMEM_WORDS);
    localparam logic [16:0] MAX_N = 17'(IMEM_WORDS);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_err;
    logic [15:0]   len_c;

    loader_state_t state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] last_q, last_d;
    logic [1:0]    lane_q, lane_d;
    logic [23:0]   lo_q, lo_d;
    logic [7:0]    csum_q, csum_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          core_reset_q, done_q, error_q;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign len_c      = {byte_data, len_lo_q};
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

    // Loader state and registered outputs; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            len_lo_q     <= '0;
            idx_q        <= '0;
            last_q       <= '0;
            lane_q       <= '0;
            lo_q         <= '0;
            csum_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            lane_q       <= lane_d;
            lo_q         <= lo_d;
            csum_q       <= csum_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            core_reset_q <= (state_d != DONE);
            done_q       <= (state_d == DONE);
            error_q      <= (state_d == ERROR);
        end
    end

    // Frame parser: header, length check, word assembly with running XOR, checksum.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        idx_d    = idx_q;
        last_d   = last_q;
        lane_d   = lane_q;
        lo_d     = lo_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (frame_err && (state_q != SYNC) && (state_q != DONE) && (state_q != ERROR)) begin
            state_d = ERROR;
        end else if (byte_valid) begin
            case (state_q)
                SYNC, DONE, ERROR: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d = LEN_LO;
                    end
                end
                LEN_LO: begin
                    len_lo_d = byte_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    if ((len_c == 16'd0) || ({1'b0, len_c} > MAX_N)) begin
                        state_d = ERROR;
                    end else begin
                        last_d  = AW'(len_c - 16'd1);
                        idx_d   = '0;
                        lane_d  = '0;
                        csum_d  = '0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d = csum_q ^ byte_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: lo_d[7:0]   = byte_data;
                        2'd1: lo_d[15:8]  = byte_data;
                        2'd2: lo_d[23:16] = byte_data;
                        default: begin
                            we_d   = 1'b1;
                            addr_d = idx_q;
                            data_d = {byte_data, lo_q};
                            idx_d  = idx_q + AW'(1);
                            if (idx_q == last_q) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
                CSUM: begin
                    state_d = (byte_data == csum_q) ? DONE : ERROR;
                end
                default: state_d = SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scenario bench for uart_imem_loader: expected imem writes are queued as frames are sent.
module tb_uart_imem_loader;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned BAUD       = 100_000;
    localparam int unsigned IMEM_WORDS = 1024;
    localparam int unsigned DIV        = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        core_reset;
    logic        done;
    logic        error;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [41:0] exp_q[$];

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    // Scoreboard: every write strobe must match the oldest expected write.
    task automatic write_monitor();
        logic [41:0] e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: got addr=%0d data=%08h, required no write", imem_addr, imem_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({imem_addr, imem_data} !== e) begin
                        n_err++;
                        $display("FAIL write_value: got addr=%0d data=%08h, required addr=%0d data=%08h",
                                 imem_addr, imem_data, e[41:32], e[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (stop_bit ? 2 * DIV : 15 * DIV) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    // Full frame of up to two words; the words are expected at addresses 0 and 1.
    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        send_byte(8'(n >> 8), 1'b1);
        exp_q.push_back({10'd0, w0});
        send_word(w0);
        if (n > 1) begin
            exp_q.push_back({10'd1, w1});
            send_word(w1);
        end
        send_byte(cs, 1'b1);
    endtask

    task automatic check_status(input string name, input logic e_done, input logic e_err, input logic e_cr);
        n_cmp++;
        if ({done, error, core_reset} !== {e_done, e_err, e_cr}) begin
            n_err++;
            $display("FAIL %s: got done/error/core_reset=%b%b%b, required %b%b%b",
                     name, done, error, core_reset, e_done, e_err, e_cr);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_writes: got %0d expected writes still pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({imem_we, imem_addr, imem_data, done, error, core_reset} !== {1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values: got we=%b addr=%0d data=%08h done=%b error=%b core_reset=%b, required 0 0 0 0 0 1",
                     imem_we, imem_addr, imem_data, done, error, core_reset);
        end
        reset = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        check_status("idle_after_reset", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_load();
        send_frame(2, 32'h5000_0117, 32'h5001_0113, 8'h05);
        check_status("load_good", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_csum();
        send_frame(2, 32'h5000_0117, 32'h5001_0113, 8'h06);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_len_faults();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check_status("len_zero", 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        check_status("len_too_big", 1'b0, 1'b1, 1'b1);
        send_frame(1, 32'h0000_0013, 32'h0, 8'h13);
        check_status("len_recover", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_noise();
        send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        check_status("noise_ignored_in_done", 1'b1, 1'b0, 1'b0);
        send_frame(2, 32'h5000_0117, 32'h5001_0113, 8'h05);
        check_status("noise_then_load", 1'b1, 1'b0, 1'b0);
        // A short low pulse mid-frame must not become a data byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        exp_q.push_back({10'd0, 32'h0000_0013});
        send_word(32'h0000_0013);
        send_byte(8'h13, 1'b1);
        check_status("glitch_ignored", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stop_err();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h17, 1'b1);
        send_byte(8'h01, 1'b0);
        check_status("stop_bit_low", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_frame(2, 32'h5000_0117, 32'h5001_0113, 8'h05);
        check_status("pre_mid_load", 1'b1, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h17, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        // Partial seventh byte in flight when reset hits.
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({imem_we, imem_addr, imem_data, done, error, core_reset} !== {1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset_values: got we=%b addr=%0d data=%08h done=%b error=%b core_reset=%b, required 0 0 0 0 0 1",
                     imem_we, imem_addr, imem_data, done, error, core_reset);
        end
        reset = 1'b0;
        repeat (12 * DIV) @(negedge clk);
        check_status("after_mid_reset_idle", 1'b0, 1'b0, 1'b1);
        send_frame(2, 32'h5000_0117, 32'h5001_0113, 8'h05);
        check_status("reload_after_reset", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        fork
            write_monitor();
        join_none
        @(negedge clk);
        test_reset();
        test_load();
        test_bad_csum();
        test_len_faults();
        test_noise();
        test_stop_err();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
